// File: rtl/axil_cfg_pkg.sv
// rtl/axil_cfg_pkg.sv - shared types and constants for the AXI4-Lite config master
package axil_cfg_pkg;

  localparam int unsigned CFG_ADDR_W = 5;
  localparam int unsigned CFG_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WB,
    RD,
    RW,
    RSP
  } state_e;

endpackage

// File: rtl/axil_cfg_master.sv
// rtl/axil_cfg_master.sv - one-outstanding command/response to AXI4-Lite initiator
// Optional per-phase watchdog enabled by AXIL_CFG_MASTER_TIMEOUT_EN
module axil_cfg_master
  import axil_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W      = CFG_ADDR_W,
  parameter int unsigned DATA_W      = CFG_DATA_W,
  parameter int unsigned STRB_W      = DATA_W / 8,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              m_axi_config_AWVALID,
  input  logic              m_axi_config_AWREADY,
  output logic [ADDR_W-1:0] m_axi_config_AWADDR,
  output logic              m_axi_config_WVALID,
  input  logic              m_axi_config_WREADY,
  output logic [DATA_W-1:0] m_axi_config_WDATA,
  output logic [STRB_W-1:0] m_axi_config_WSTRB,
  input  logic              m_axi_config_BVALID,
  output logic              m_axi_config_BREADY,
  input  logic [1:0]        m_axi_config_BRESP,
  output logic              m_axi_config_ARVALID,
  input  logic              m_axi_config_ARREADY,
  output logic [ADDR_W-1:0] m_axi_config_ARADDR,
  input  logic              m_axi_config_RVALID,
  output logic              m_axi_config_RREADY,
  input  logic [DATA_W-1:0] m_axi_config_RDATA,
  input  logic [1:0]        m_axi_config_RRESP
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic              aw_done_q, w_done_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_resp_q;

  logic              aw_done_d, w_done_d;
  logic              phase_done;
  logic              in_phase;
  logic              tmo_hit;

  // phase_done is the condition that moves a waiting state forward this cycle
  always_comb begin
    aw_done_d  = aw_done_q | (awvalid_q & m_axi_config_AWREADY);
    w_done_d   = w_done_q | (wvalid_q & m_axi_config_WREADY);
    phase_done = 1'b0;
    case (state_q)
      WR:      phase_done = aw_done_d & w_done_d;
      WB:      phase_done = m_axi_config_BVALID;
      RD:      phase_done = m_axi_config_ARREADY;
      RW:      phase_done = m_axi_config_RVALID;
      default: phase_done = 1'b0;
    endcase
  end

  assign in_phase = (state_q == WR) || (state_q == WB) || (state_q == RD) || (state_q == RW);

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             rsp_timeout_q;

  assign tmo_hit     = in_phase && !phase_done && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_timeout = rsp_timeout_q;

  // Counter restarts on every state change, so each channel phase gets its own budget
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (!in_phase || phase_done || tmo_hit) tmo_cnt_q <= '0;
      else                                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (cmd_valid && cmd_ready) rsp_timeout_q <= 1'b0;
      else if (tmo_hit)           rsp_timeout_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYC == 0) | in_phase;
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else if (tmo_hit) begin
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_SLVERR;
      state_q     <= RSP;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q    <= cmd_addr;
          wdata_q   <= cmd_wdata;
          wstrb_q   <= cmd_wstrb;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (cmd_write) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= WR;
          end else begin
            arvalid_q <= 1'b1;
            state_q   <= RD;
          end
        end
        WR: begin
          // AW and W retire independently; each VALID drops the cycle after its handshake
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          awvalid_q <= ~aw_done_d;
          wvalid_q  <= ~w_done_d;
          if (phase_done) begin
            bready_q <= 1'b1;
            state_q  <= WB;
          end
        end
        WB: if (m_axi_config_BVALID) begin
          bready_q    <= 1'b0;
          rsp_resp_q  <= m_axi_config_BRESP;
          rsp_rdata_q <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RD: if (m_axi_config_ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RW;
        end
        RW: if (m_axi_config_RVALID) begin
          rready_q    <= 1'b0;
          rsp_rdata_q <= m_axi_config_RDATA;
          rsp_resp_q  <= m_axi_config_RRESP;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready            = (state_q == IDLE);
  assign busy                 = (state_q != IDLE);
  assign rsp_valid            = rsp_valid_q;
  assign rsp_rdata            = rsp_rdata_q;
  assign rsp_resp             = rsp_resp_q;
  assign m_axi_config_AWVALID = awvalid_q;
  assign m_axi_config_AWADDR  = addr_q;
  assign m_axi_config_WVALID  = wvalid_q;
  assign m_axi_config_WDATA   = wdata_q;
  assign m_axi_config_WSTRB   = wstrb_q;
  assign m_axi_config_BREADY  = bready_q;
  assign m_axi_config_ARVALID = arvalid_q;
  assign m_axi_config_ARADDR  = addr_q;
  assign m_axi_config_RREADY  = rready_q;

endmodule

// File: doc/axil_cfg_master.md
Name: axil_cfg_master

Overview:
- AXI4-Lite initiator that drives the s_axi_config slave port of the HLS accelerator, and of any equivalent config target, in the equivalence/verification harness.
- Converts a simple one-outstanding command/response interface into AXI4-Lite write (AW/W/B) and read (AR/R) transactions.
- Lets benches and wrappers program accelerator registers (ap_start, image dimensions, status polling) without hand-driving AXI channels.

Parameters:
ADDR_W, 5, config address width (matches C_S_AXI_CONFIG_ADDR_WIDTH)
DATA_W, 32, config data width
STRB_W, DATA_W/8, write-strobe width
TIMEOUT_CYC, 256, wait-cycle limit per channel phase (used only with the optional feature)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  register byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  STRB_W  write byte enables
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  captured BRESP/RRESP
rsp_timeout  out  1  transaction aborted by timeout
busy  out  1  state != IDLE
m_axi_config_AWVALID/AWREADY/AWADDR  out/in/out  1/1/ADDR_W  write address channel
m_axi_config_WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/DATA_W/STRB_W  write data channel
m_axi_config_BVALID/BREADY/BRESP  in/out/in  1/1/2  write response channel
m_axi_config_ARVALID/ARREADY/ARADDR  out/in/out  1/1/ADDR_W  read address channel
m_axi_config_RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/DATA_W/2  read data channel

Behaviour:
- Reset (async assert, sync release): state=IDLE; all AXI VALID/READY outputs 0; rsp_valid=0; rsp_rdata=0; rsp_resp=0; rsp_timeout=0; captured cmd registers 0.
- cmd_ready = (state==IDLE), combinational from state; 1 immediately after reset.
- States:
  - IDLE: on cmd_valid: latch addr, wdata, wstrb. Go to WR if cmd_write, else RD.
  - WR: AWVALID and WVALID both rise the cycle after acceptance. Each drops independently in the cycle after its own handshake (VALID&READY); per-channel done flags track this. Handshakes may complete in either order or together. When both are done, go to WB.
  - WB: BREADY=1. On BVALID, capture BRESP into rsp_resp, set rsp_rdata=0, go to RSP.
  - RD: ARVALID=1 until ARREADY, then go to RW.
  - RW: RREADY=1. On RVALID, capture RDATA and RRESP, go to RSP.
  - RSP: rsp_valid=1; rsp_* held stable until rsp_ready. Go to IDLE in the cycle after the handshake (rsp_valid drops).
- VALID signals never depend combinationally on READY. Address, data and strobe stay stable while VALID is high.
- Best-case latency with always-ready slave:
  - Write: cmd accepted at T0; AW/W handshake T1; B handshake T2; rsp_valid T3.
  - Read: AR handshake T1; R handshake T2; rsp_valid T3.
- One transaction outstanding at a time; no pipelining of commands.
- Slave SLVERR/DECERR codes are passed through unchanged; they do not abort the transaction.
- ap_rst_n asserted mid-transaction: immediate return to IDLE with all VALIDs low. The slave is reset together with the master (the harness guarantees this).

Optional Feature:
- Macro AXIL_CFG_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on every state entry and increments each cycle in WR/WB/RD/RW.
  - On reaching TIMEOUT_CYC-1 without completion: deassert all VALID/READY outputs, set rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, go to RSP.
  - rsp_timeout clears on the next command acceptance.
  - A late slave response after abort is not tracked.
- Not defined: no counter; the block waits indefinitely; rsp_timeout is tied 0.

Decomposition:
- Package axil_cfg_pkg:
  - Response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State enum (IDLE, WR, WB, RD, RW, RSP).
  - Default width constants.
- Single module, no sub-module. Channel logic is small and shares the one FSM.

Test Plan:
- Write addr 0x10, data 0x12345678, strb 0xF, slave always ready -> AW/W handshake T1, B T2, rsp_valid T3 with rsp_resp=00, rsp_rdata=0.
- Same write with WREADY delayed 3 cycles after AWREADY -> AWVALID drops after its handshake; WVALID held with stable data until WREADY; exactly one B accepted; response OK.
- Read addr 0x00, slave returns RDATA 0x00000004 and RRESP 00 after 2-cycle ARREADY stall -> rsp_rdata=0x4, rsp_resp=00.
- Read with slave RRESP=2'b10 and rsp_ready held low 5 cycles -> rsp_valid and rsp_resp=10 stable for 5 cycles; cmd_ready=0 until the cycle after the handshake.
- ap_rst_n pulsed low while WVALID is pending -> all VALIDs 0 within the same cycle; state IDLE; cmd_ready=1 after release.
- With AXIL_CFG_MASTER_TIMEOUT_EN and TIMEOUT_CYC=16, BVALID never asserted -> rsp_valid with rsp_timeout=1, rsp_resp=10 after 16 WB cycles; BREADY low afterwards.
